// File: rtl/mmio_responder.sv
// mmio_responder: memory-mapped register block on the data-memory port.
// Serves LED, debounced switches, a free-running cycle counter and a
// countdown timer with a 1-cycle synchronous read and byte-enabled writes.
module mmio_responder #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter logic [7:0]  LED_RESET       = 8'h00
) (
  input  logic        sysclk,
  input  logic        rstd,
  input  logic        sel,
  input  logic [7:0]  addr,
  input  logic [3:0]  wren,
  input  logic [31:0] w_data,
  output logic [31:0] r_data,
  input  logic [7:0]  sw,
  output logic [7:0]  led,
  output logic        irq
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned SW_W   = 8;
  localparam int unsigned IDX_W  = 6;
  localparam int unsigned CNT_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [IDX_W-1:0] IDX_LED   = 6'd0;
  localparam logic [IDX_W-1:0] IDX_SW    = 6'd1;
  localparam logic [IDX_W-1:0] IDX_COUNT = 6'd2;
  localparam logic [IDX_W-1:0] IDX_LOAD  = 6'd3;
  localparam logic [IDX_W-1:0] IDX_CTRL  = 6'd4;
  localparam logic [IDX_W-1:0] IDX_VAL   = 6'd5;

  // Register state
  logic [DATA_W-1:0] count;
  logic [DATA_W-1:0] load;
  logic [DATA_W-1:0] val;
  logic              timer_en;
  logic              timer_auto;
  logic              timer_exp;

  // Switch path state
  logic [SW_W-1:0]   sw_meta;
  logic [SW_W-1:0]   sw_s;
  logic [SW_W-1:0]   sw_db;
  logic [CNT_W-1:0]  db_cnt;

  // Decode and next-state signals
  logic [IDX_W-1:0]  idx_c;
  logic              led_wr_c;
  logic              load_wr_c;
  logic              ctrl_wr_c;
  logic              expire_c;
  logic [DATA_W-1:0] load_merged_c;
  logic [DATA_W-1:0] load_next_c;
  logic [DATA_W-1:0] val_next_c;
  logic              en_next_c;
  logic              auto_next_c;
  logic              exp_next_c;
  logic [DATA_W-1:0] rd_c;
  logic              unused_addr_c;

  assign idx_c         = addr[7:2];
  assign unused_addr_c = ^addr[1:0];
  assign irq           = timer_exp;

  // Byte-lane merge of write data into a 32-bit register
  function automatic logic [DATA_W-1:0] merge_lanes(input logic [DATA_W-1:0] old_v,
                                                    input logic [DATA_W-1:0] new_v,
                                                    input logic [3:0]        be);
    logic [DATA_W-1:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) r[8*b +: 8] = new_v[8*b +: 8];
    end
    return r;
  endfunction

  // Address decode, timer next-state and read mux (all from pre-edge state)
  always_comb begin
    led_wr_c      = 1'b0;
    load_wr_c     = 1'b0;
    ctrl_wr_c     = 1'b0;
    expire_c      = 1'b0;
    load_merged_c = merge_lanes(load, w_data, wren);
    load_next_c   = load;
    val_next_c    = val;
    en_next_c     = timer_en;
    auto_next_c   = timer_auto;
    exp_next_c    = timer_exp;
    rd_c          = '0;

    if (sel) begin
      led_wr_c  = (idx_c == IDX_LED) && wren[0];
      load_wr_c = (idx_c == IDX_LOAD) && (wren != 4'b0000);
      ctrl_wr_c = (idx_c == IDX_CTRL);
      case (idx_c)
        IDX_LED:   rd_c = DATA_W'(led);
        IDX_SW:    rd_c = DATA_W'(sw_db);
        IDX_COUNT: rd_c = count;
        IDX_LOAD:  rd_c = load;
        IDX_CTRL:  rd_c = {23'h0, timer_exp, 6'h0, timer_auto, timer_en};
        IDX_VAL:   rd_c = val;
        default:   rd_c = '0;
      endcase
    end

    // A LOAD write reloads the countdown and suppresses this cycle's tick
    if (load_wr_c) begin
      load_next_c = load_merged_c;
      val_next_c  = load_merged_c;
    end else if (timer_en) begin
      if (val != '0) begin
        val_next_c = val - DATA_W'(1);
      end else begin
        expire_c = 1'b1;
        if (timer_auto) val_next_c = load;
        else            en_next_c  = 1'b0;
      end
    end

    // Software-written EN/AUTO overrides the one-shot auto-clear
    if (ctrl_wr_c && wren[0]) begin
      en_next_c   = w_data[0];
      auto_next_c = w_data[1];
    end

    // Expiry set wins over a simultaneous write-1-to-clear
    if (expire_c) begin
      exp_next_c = 1'b1;
    end else if (ctrl_wr_c && wren[1] && w_data[8]) begin
      exp_next_c = 1'b0;
    end
  end

  // Register file, counter, timer and read data
  always_ff @(posedge sysclk or negedge rstd) begin
    if (!rstd) begin
      led        <= LED_RESET;
      count      <= '0;
      load       <= '0;
      val        <= '0;
      timer_en   <= 1'b0;
      timer_auto <= 1'b0;
      timer_exp  <= 1'b0;
      r_data     <= '0;
    end else begin
      if (led_wr_c) led <= w_data[7:0];
      count      <= count + DATA_W'(1);
      load       <= load_next_c;
      val        <= val_next_c;
      timer_en   <= en_next_c;
      timer_auto <= auto_next_c;
      timer_exp  <= exp_next_c;
      r_data     <= rd_c;
    end
  end

  // Two-flop synchronizer followed by a stable-count debouncer
  always_ff @(posedge sysclk or negedge rstd) begin
    if (!rstd) begin
      sw_meta <= '0;
      sw_s    <= '0;
      sw_db   <= '0;
      db_cnt  <= '0;
    end else begin
      sw_meta <= sw;
      sw_s    <= sw_meta;
      if (sw_s == sw_db) begin
        db_cnt <= '0;
      end else if (db_cnt == CNT_LAST) begin
        sw_db  <= sw_s;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mmio_responder.sv
// tb_mmio_responder: directed scenarios plus randomized traffic, checked
// against a register-level reference model of the MMIO block.
module tb_mmio_responder;

  localparam int unsigned DEB = 16;

  logic        sysclk = 1'b0;
  logic        rstd;
  logic        sel;
  logic [7:0]  addr;
  logic [3:0]  wren;
  logic [31:0] w_data;
  logic [31:0] r_data;
  logic [7:0]  sw;
  logic [7:0]  led;
  logic        irq;

  int vectors     = 0;
  int miscompares = 0;

  mmio_responder #(.DEBOUNCE_CYCLES(DEB), .LED_RESET(8'h00)) dut (
    .sysclk (sysclk),
    .rstd   (rstd),
    .sel    (sel),
    .addr   (addr),
    .wren   (wren),
    .w_data (w_data),
    .r_data (r_data),
    .sw     (sw),
    .led    (led),
    .irq    (irq)
  );

  always #5 sysclk = ~sysclk;

  // Reference model state
  logic [7:0]  m_led, m_sw1, m_sw2, m_db;
  int          m_run;
  logic [31:0] m_count, m_load, m_val, m_rdata;
  logic        m_en, m_auto, m_exp;

  function automatic logic [31:0] lanes(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  task automatic model_reset();
    m_led = 8'h00; m_sw1 = 0; m_sw2 = 0; m_db = 0; m_run = 0;
    m_count = 0; m_load = 0; m_val = 0; m_rdata = 0;
    m_en = 0; m_auto = 0; m_exp = 0;
  endtask

  // One clock edge of the register map, using the inputs currently presented
  task automatic model_edge();
    logic [31:0] rd;
    logic        lw, cw, fire;
    rd = 0;
    if (sel) begin
      case (addr[7:2])
        6'd0:    rd = {24'h0, m_led};
        6'd1:    rd = {24'h0, m_db};
        6'd2:    rd = m_count;
        6'd3:    rd = m_load;
        6'd4:    rd = {23'h0, m_exp, 6'h0, m_auto, m_en};
        6'd5:    rd = m_val;
        default: rd = 0;
      endcase
    end
    lw   = sel && (addr[7:2] == 6'd3) && (wren != 0);
    cw   = sel && (addr[7:2] == 6'd4);
    fire = 0;
    if (lw) begin
      m_load = lanes(m_load, w_data, wren);
      m_val  = m_load;
    end else if (m_en) begin
      if (m_val != 0) m_val = m_val - 1;
      else begin
        fire = 1;
        if (m_auto) m_val = m_load;
        else        m_en  = 0;
      end
    end
    if (cw && wren[0]) begin m_en = w_data[0]; m_auto = w_data[1]; end
    if (fire) m_exp = 1;
    else if (cw && wren[1] && w_data[8]) m_exp = 0;
    if (sel && (addr[7:2] == 6'd0) && wren[0]) m_led = w_data[7:0];
    m_count = m_count + 1;
    // a new synchronized value is accepted after differing for DEB consecutive cycles
    if (m_sw2 != m_db) begin
      m_run++;
      if (m_run == DEB) begin m_db = m_sw2; m_run = 0; end
    end else m_run = 0;
    m_sw2   = m_sw1;
    m_sw1   = sw;
    m_rdata = rd;
  endtask

  task automatic drive(input logic s, input logic [7:0] a, input logic [3:0] we,
                       input logic [31:0] wd);
    sel = s; addr = a; wren = we; w_data = wd;
  endtask

  // Advance one clock and the model, leaving time at edge + 1
  task automatic step();
    @(posedge sysclk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] c1, c2;
    rstd = 1'b0; sw = 8'hFF; drive(0, 0, 0, 0);
    model_reset();
    #3;
    vectors++; if (led !== 8'h00) begin miscompares++; $display("FAIL reset_led: got %h want 00", led); end
    vectors++; if (r_data !== 32'h0) begin miscompares++; $display("FAIL reset_rdata: got %h want 0", r_data); end
    vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL reset_irq: got %b want 0", irq); end
    @(negedge sysclk); rstd = 1'b1;
    step();
    drive(1, 8'h08, 0, 0); step(); c1 = r_data;
    vectors++; if (r_data !== m_rdata) begin miscompares++; $display("FAIL reset_count1: got %h want %h", r_data, m_rdata); end
    drive(0, 0, 0, 0); step(); step();
    drive(1, 8'h08, 0, 0); step(); c2 = r_data;
    vectors++; if (c2 - c1 !== 32'd3) begin miscompares++; $display("FAIL reset_count_diff: got %0d want 3", c2 - c1); end
    drive(0, 0, 0, 0);
  endtask

  task automatic test_led();
    drive(1, 8'h00, 4'b0001, 32'h0000_00A5); step();
    vectors++; if (led !== 8'hA5) begin miscompares++; $display("FAIL led_write: got %h want a5", led); end
    drive(1, 8'h00, 4'b0010, 32'h0000_5A3C); step();
    vectors++; if (led !== 8'hA5) begin miscompares++; $display("FAIL led_lane1: got %h want a5", led); end
    drive(1, 8'h00, 4'b0000, 0); step();
    vectors++; if (r_data !== 32'h0000_00A5) begin miscompares++; $display("FAIL led_read: got %h want 000000a5", r_data); end
    vectors++; if (led !== m_led) begin miscompares++; $display("FAIL led_model: got %h want %h", led, m_led); end
    drive(0, 0, 0, 0);
  endtask

  task automatic test_debounce();
    int first;
    bit ok;
    sw = 8'h00;
    for (int i = 0; i < DEB + 8; i++) step();
    sw = 8'h3C;
    drive(1, 8'h04, 0, 0);
    first = 0;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (first == 0 && r_data === 32'h3C) first = i;
    end
    // two sync flops + DEB stable cycles + one read cycle
    vectors++; if (first != DEB + 3) begin miscompares++; $display("FAIL debounce_latency: got %0d want %0d", first, DEB + 3); end
    sw = 8'h00;
    for (int i = 0; i < 10; i++) step();
    sw = 8'h3C;
    ok = 1;
    for (int i = 0; i < 30; i++) begin
      step();
      if (r_data !== 32'h3C || m_rdata !== 32'h3C) ok = 0;
    end
    vectors++; if (!ok) begin miscompares++; $display("FAIL debounce_glitch: got %h want 0000003c", r_data); end
    drive(0, 0, 0, 0);
  endtask

  task automatic test_oneshot();
    logic [31:0] want;
    drive(1, 8'h0C, 4'hF, 32'd3); step();
    drive(1, 8'h10, 4'b0001, 32'h1); step();
    drive(1, 8'h14, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      want = 32'(3 - i);
      vectors++; if (r_data !== want) begin miscompares++; $display("FAIL oneshot_val%0d: got %h want %h", i, r_data, want); end
      vectors++; if (irq !== (i == 3)) begin miscompares++; $display("FAIL oneshot_irq%0d: got %b want %b", i, irq, (i == 3)); end
    end
    drive(1, 8'h10, 0, 0); step();
    vectors++; if (r_data !== 32'h100) begin miscompares++; $display("FAIL oneshot_ctrl: got %h want 00000100", r_data); end
    drive(1, 8'h10, 4'b0010, 32'h100); step();
    vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL oneshot_w1c: got %b want 0", irq); end
    drive(0, 0, 0, 0);
  endtask

  task automatic test_auto();
    logic [31:0] want;
    drive(1, 8'h0C, 4'hF, 32'd2); step();
    drive(1, 8'h10, 4'b0001, 32'h3); step();
    drive(1, 8'h14, 0, 0);
    for (int i = 0; i < 6; i++) begin
      step();
      want = 32'(2 - (i % 3));
      vectors++; if (r_data !== want) begin miscompares++; $display("FAIL auto_val%0d: got %h want %h", i, r_data, want); end
      vectors++; if (irq !== (i >= 2)) begin miscompares++; $display("FAIL auto_irq%0d: got %b want %b", i, irq, (i >= 2)); end
    end
    drive(1, 8'h10, 4'b0010, 32'h100); step();
    vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL auto_w1c: got %b want 0", irq); end
    drive(0, 0, 0, 0); step();
    drive(1, 8'h10, 4'b0010, 32'h100); step();
    vectors++; if (irq !== 1'b1) begin miscompares++; $display("FAIL auto_w1c_vs_expire: got %b want 1", irq); end
    drive(1, 8'h10, 4'b0011, 32'h100); step();
    vectors++; if (irq !== m_exp || irq !== 1'b0) begin miscompares++; $display("FAIL auto_stop: got %b want 0", irq); end
    drive(0, 0, 0, 0);
  endtask

  task automatic test_rw_same_edge();
    drive(1, 8'h0C, 4'hF, 32'd7); step();
    vectors++; if (r_data !== 32'd2) begin miscompares++; $display("FAIL rw_old_load: got %h want 00000002", r_data); end
    drive(1, 8'h0C, 0, 0); step();
    vectors++; if (r_data !== 32'd7) begin miscompares++; $display("FAIL rw_new_load: got %h want 00000007", r_data); end
    drive(1, 8'h3C, 4'hF, 32'hFFFF_FFFF); step();
    vectors++; if (r_data !== 32'h0) begin miscompares++; $display("FAIL rw_unmapped: got %h want 0", r_data); end
    drive(0, 8'h08, 0, 0); step();
    vectors++; if (r_data !== 32'h0) begin miscompares++; $display("FAIL rw_nosel: got %h want 0", r_data); end
    drive(0, 0, 0, 0);
  endtask

  task automatic test_reset_midop();
    drive(1, 8'h08, 0, 0); step();
    #2 rstd = 1'b0;
    #1;
    model_reset();
    vectors++; if (r_data !== 32'h0) begin miscompares++; $display("FAIL midrst_rdata: got %h want 0", r_data); end
    vectors++; if (led !== 8'h00) begin miscompares++; $display("FAIL midrst_led: got %h want 00", led); end
    vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL midrst_irq: got %b want 0", irq); end
    drive(0, 0, 0, 0);
    @(negedge sysclk); rstd = 1'b1;
  endtask

  task automatic test_random();
    int k;
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 24) == 0) sw = 8'($urandom);
      k = $urandom_range(0, 7);
      if (k >= 6) addr = {6'($urandom_range(6, 63)), 2'($urandom)};
      else        addr = {6'(k), 2'($urandom)};
      sel    = ($urandom_range(0, 3) != 0);
      wren   = ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'b0000;
      w_data = (k == 3) ? 32'($urandom_range(0, 6)) : 32'($urandom);
      step();
      vectors++; if (r_data !== m_rdata) begin miscompares++; $display("FAIL rand_rdata@%0d: got %h want %h", n, r_data, m_rdata); end
      vectors++; if (led !== m_led) begin miscompares++; $display("FAIL rand_led@%0d: got %h want %h", n, led, m_led); end
      vectors++; if (irq !== m_exp) begin miscompares++; $display("FAIL rand_irq@%0d: got %b want %b", n, irq, m_exp); end
    end
    drive(0, 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_led();
    test_debounce();
    test_oneshot();
    test_auto();
    test_rw_same_edge();
    test_reset_midop();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
